// File: rtl/hs_arbiter.sv
// hs_arbiter: round-robin arbiter that merges N four-phase request/acknowledge
// channels onto one shared four-phase downstream channel.
//
// Ports
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous reset, active low
//   lr    left request, one bit per requester
//   la    left acknowledge, one bit per requester (registered, at most one high)
//   rr    request to the shared downstream channel (registered)
//   ra    acknowledge from the shared downstream channel
//   le    one-cycle latch-enable pulse for the shared data latch (registered)
//   sel   index of the granted requester, valid while busy=1 (registered)
//   busy  high from grant until the transaction returns to IDLE (registered)
//
// state | meaning
// IDLE  | no transaction; arbitrate round-robin from ptr
// CAPT  | winner chosen; le pulses to capture its data
// RREQ  | rr high, waiting for ra
// LACK  | rr high, la[sel] high, waiting for lr[sel] to drop
// RREL  | rr and la low, waiting for ra to drop
module hs_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] lr,
  output logic [N-1:0] la,
  output logic         rr,
  input  logic         ra,
  output logic         le,
  output logic [2:0]   sel,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAPT = 3'd1,
    RREQ = 3'd2,
    LACK = 3'd3,
    RREL = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic [2:0]   ptr, ptr_nxt;
  logic [2:0]   sel_nxt;
  logic [2:0]   winner;
  logic         any_req;
  logic         lr_sel;
  logic [N-1:0] la_nxt;
  logic         rr_nxt, le_nxt, busy_nxt;

  // Round-robin search. Indices are compared against loop constants rather
  // than used as variable bit selects, which keeps widths exact for any N.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!any_req && (j == idx) && lr[j]) begin
          any_req = 1'b1;
          winner  = 3'(j);
        end
      end
    end
  end

  always_comb begin
    lr_sel = 1'b0;
    for (int j = 0; j < N; j++) begin
      if ((3'(j) == sel) && lr[j]) lr_sel = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = CAPT;
          sel_nxt   = winner;
        end
      end
      CAPT: state_nxt = RREQ;
      RREQ: if (ra) state_nxt = LACK;
      LACK: if (!lr_sel) state_nxt = RREL;
      RREL: begin
        if (!ra) begin
          state_nxt = IDLE;
          ptr_nxt   = (sel == 3'(N - 1)) ? 3'd0 : sel + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // is valid in the same cycle the FSM occupies the corresponding state.
  always_comb begin
    le_nxt   = (state_nxt == CAPT);
    rr_nxt   = (state_nxt == RREQ) || (state_nxt == LACK);
    busy_nxt = (state_nxt != IDLE);
    for (int j = 0; j < N; j++) begin
      la_nxt[j] = (state_nxt == LACK) && (3'(j) == sel_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      la   <= '0;
      rr   <= 1'b0;
      le   <= 1'b0;
      busy <= 1'b0;
    end else begin
      la   <= la_nxt;
      rr   <= rr_nxt;
      le   <= le_nxt;
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hs_arbiter.sv
module tb_hs_arbiter;

  localparam int N = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] lr;
  logic [N-1:0] la;
  logic         rr;
  logic         ra;
  logic         le;
  logic [2:0]   sel;
  logic         busy;

  int checks = 0;
  int errors = 0;

  hs_arbiter #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .lr   (lr),
    .la   (la),
    .rr   (rr),
    .ra   (ra),
    .le   (le),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full minimum-length transaction starting in IDLE with lr already set.
  // Optionally re-raises the requester's lr as the transaction closes.
  task automatic run_txn(input int exp_sel, input bit reraise);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[exp_sel] = 1'b1;
    tick();
    chk("capt_le", le, 1);
    chk("capt_busy", busy, 1);
    chk("capt_sel", sel, exp_sel);
    chk("capt_rr", rr, 0);
    chk("capt_la", la, 0);
    tick();
    chk("rreq_rr", rr, 1);
    chk("rreq_le", le, 0);
    chk("rreq_la", la, 0);
    ra = 1'b1;
    tick();
    chk("lack_la", la, onehot);
    chk("lack_rr", rr, 1);
    lr[exp_sel] = 1'b0;
    tick();
    chk("rrel_la", la, 0);
    chk("rrel_rr", rr, 0);
    chk("rrel_busy", busy, 1);
    ra = 1'b0;
    if (reraise) lr[exp_sel] = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_la", la, 0);
  endtask

  initial begin
    rst = 1'b0;
    lr  = '0;
    ra  = 1'b0;
    tick();
    tick();
    chk("rst_la", la, 0);
    chk("rst_rr", rr, 0);
    chk("rst_le", le, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 0);
    rst = 1'b1;
    tick();
    chk("idle_noreq_busy", busy, 0);

    // Single request on channel 0, then confirm ptr moved to 1.
    lr = 3'b001;
    run_txn(0, 0);
    lr = 3'b011;
    run_txn(1, 0);
    lr = 3'b001;
    run_txn(0, 0);

    // Round-robin with all requesters held, from a fresh reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    lr = 3'b111;
    run_txn(0, 1);
    run_txn(1, 1);
    run_txn(2, 1);
    run_txn(0, 1);
    run_txn(1, 1);
    run_txn(2, 0);
    lr = 3'b000;
    tick();
    chk("rr_done_busy", busy, 0);

    // Slow downstream on channel 1 (ptr=0 after the last grant of 2).
    lr = 3'b010;
    tick();
    chk("slow_le", le, 1);
    chk("slow_sel", sel, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("slow_rr", rr, 1);
      chk("slow_la", la, 0);
      chk("slow_le_off", le, 0);
    end
    ra = 1'b1;
    tick();
    chk("slow_lack", la, 3'b010);
    lr = 3'b000;
    tick();
    ra = 1'b0;
    tick();
    chk("slow_idle", busy, 0);

    // Pending request on channel 2 while channel 0 is serviced (ptr=2).
    lr = 3'b001;
    tick();
    chk("pend_sel0", sel, 0);
    tick();
    lr = 3'b101;
    ra = 1'b1;
    tick();
    chk("pend_lack0", la, 3'b001);
    lr = 3'b100;
    tick();
    chk("pend_rrel_la", la, 0);
    ra = 1'b0;
    tick();
    chk("pend_idle_la", la, 0);
    run_txn(2, 0);

    // Reset in the middle of LACK (ptr=0 now).
    lr = 3'b010;
    tick();
    tick();
    ra = 1'b1;
    tick();
    chk("rstmid_lack", la, 3'b010);
    rst = 1'b0;
    tick();
    chk("rstmid_la", la, 0);
    chk("rstmid_rr", rr, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_le", le, 0);
    rst = 1'b1;
    ra = 1'b0;
    lr = 3'b110;
    run_txn(1, 0);
    lr = 3'b000;

    // Spurious ra in IDLE and CAPT (ptr=2, so channel 0 wins via wrap).
    ra = 1'b1;
    tick();
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_rr", rr, 0);
    lr = 3'b001;
    tick();
    chk("spur_capt_le", le, 1);
    chk("spur_capt_rr", rr, 0);
    chk("spur_capt_sel", sel, 0);
    tick();
    chk("spur_rreq_rr", rr, 1);
    chk("spur_rreq_la", la, 0);
    ra = 1'b0;
    tick();
    chk("spur_hold_rr", rr, 1);
    chk("spur_hold_la", la, 0);
    ra = 1'b1;
    tick();
    chk("spur_lack", la, 3'b001);
    lr = 3'b000;
    tick();
    ra = 1'b0;
    tick();
    chk("spur_idle_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
